// File: rtl/photon_frame_buffer.sv
// Photon-count frame buffer: captures FRAME_LEN samples, then streams them out
// over valid/ready in written order (REVERSE=0) or reversed order (REVERSE=1).
module photon_frame_buffer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 128,
    parameter int REVERSE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W:0]   fill_count
);

    // Handshake: a sample transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready is low,
    // out_data and out_last hold their values. clear overrides any transfer.

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] START_PTR = (REVERSE != 0) ? LAST_PTR : '0;
    localparam logic [ADDR_W-1:0] END_PTR   = (REVERSE != 0) ? '0 : LAST_PTR;
    localparam logic [ADDR_W:0]   LAST_FILL = (ADDR_W + 1)'(FRAME_LEN - 1);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_step;
    logic [ADDR_W-1:0] rd_addr;

    logic wr_fire;
    logic wr_drop;
    logic accept;
    logic last_accept;
    logic frame_full;

    assign wr_fire     = (state == FILL) && wr_en && !clear;
    assign wr_drop     = (state == DRAIN) && wr_en && !clear;
    assign frame_full  = wr_fire && (fill_count == LAST_FILL);
    assign accept      = out_valid && out_ready && !clear;
    assign last_accept = accept && out_last;

    // ram_q is kept pointing at the sample out_valid presents: the read
    // address advances in the same cycle a non-final sample is accepted.
    always_comb begin
        rd_ptr_step = (REVERSE != 0) ? (rd_ptr - 1'b1) : (rd_ptr + 1'b1);
        rd_addr     = (accept && !out_last) ? rd_ptr_step : rd_ptr;
    end

    // Simple dual-port RAM, synchronous read, no reset on the read register.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[fill_count[ADDR_W-1:0]] <= wr_data;
        end
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (frame_full)  state_next = DRAIN;
                DRAIN:   if (last_accept) state_next = FILL;
                default: state_next = FILL;
            endcase
        end
    end

    always_comb begin
        busy     = (state == DRAIN);
        out_last = out_valid && (rd_ptr == END_PTR);
        out_data = out_valid ? ram_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_count <= '0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            fill_count <= '0;
            rd_ptr     <= START_PTR;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= last_accept;
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (wr_fire) begin
                fill_count <= fill_count + 1'b1;
                if (frame_full) begin
                    rd_ptr <= START_PTR;
                end
            end
            // First DRAIN cycle reads the start sample; it is valid one edge
            // later, which also covers the sample written on the entry edge.
            if (state == DRAIN) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                end else if (accept) begin
                    if (out_last) begin
                        out_valid  <= 1'b0;
                        fill_count <= '0;
                    end else begin
                        rd_ptr <= rd_ptr_step;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_photon_frame_buffer.sv
// Directed bench for photon_frame_buffer: four instances cover forward, reverse,
// back-pressure/overflow/clear and a full DEPTH-sized frame.
module tb_photon_frame_buffer;

    localparam int NI = 4;

    logic                clk;
    logic                rst;
    logic [NI-1:0]       clear;
    logic [NI-1:0]       wr_en;
    logic [NI-1:0][15:0] wr_data;
    logic [NI-1:0]       out_ready;
    logic [NI-1:0]       out_valid;
    logic [NI-1:0][15:0] out_data;
    logic [NI-1:0]       out_last;
    logic [NI-1:0]       frame_done;
    logic [NI-1:0]       busy;
    logic [NI-1:0]       overflow;
    logic [NI-1:0][10:0] fill_count;

    logic [15:0] exp_q[$];
    logic [15:0] stim_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int first_cyc;
    int last_cyc;

    photon_frame_buffer #(.DATA_W(16), .DEPTH(1024), .ADDR_W(10), .FRAME_LEN(4), .REVERSE(0)) u_fwd (
        .clk(clk), .rst(rst), .clear(clear[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .out_ready(out_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .frame_done(frame_done[0]), .busy(busy[0]),
        .overflow(overflow[0]), .fill_count(fill_count[0])
    );

    photon_frame_buffer #(.DATA_W(16), .DEPTH(1024), .ADDR_W(10), .FRAME_LEN(4), .REVERSE(1)) u_rev (
        .clk(clk), .rst(rst), .clear(clear[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .out_ready(out_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .frame_done(frame_done[1]), .busy(busy[1]),
        .overflow(overflow[1]), .fill_count(fill_count[1])
    );

    photon_frame_buffer #(.DATA_W(16), .DEPTH(1024), .ADDR_W(10), .FRAME_LEN(8), .REVERSE(0)) u_bp (
        .clk(clk), .rst(rst), .clear(clear[2]), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .out_ready(out_ready[2]), .out_valid(out_valid[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .frame_done(frame_done[2]), .busy(busy[2]),
        .overflow(overflow[2]), .fill_count(fill_count[2])
    );

    photon_frame_buffer #(.DATA_W(16), .DEPTH(1024), .ADDR_W(10), .FRAME_LEN(1024), .REVERSE(0)) u_full (
        .clk(clk), .rst(rst), .clear(clear[3]), .wr_en(wr_en[3]), .wr_data(wr_data[3]),
        .out_ready(out_ready[3]), .out_valid(out_valid[3]), .out_data(out_data[3]),
        .out_last(out_last[3]), .frame_done(frame_done[3]), .busy(busy[3]),
        .overflow(overflow[3]), .fill_count(fill_count[3])
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Writes stim_q on consecutive cycles; the scoreboard gets the frame in
    // readout order. Returns with wr_en still high for the last sample.
    task automatic write_frame(input int k, input bit rev);
        foreach (stim_q[i]) begin
            @(negedge clk);
            wr_en[k]   = 1'b1;
            wr_data[k] = stim_q[i];
            if (rev) exp_q.push_front(stim_q[i]);
            else     exp_q.push_back(stim_q[i]);
        end
    endtask

    // mode 0: always ready; mode 1: ready 1,0,0,1,0,0...; mode 2: ready 0,1,0,1...
    task automatic drain(input int k, input int n, input int mode, input int budget,
                         output int f_cyc, output int l_cyc);
        int  got = 0;
        int  cyc = 0;
        logic r;
        logic prev_hold = 1'b0;
        f_cyc = -1;
        l_cyc = -1;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = (cyc % 2 == 1);
            endcase
            if (prev_hold) check("hold_valid", out_valid[k], 1);
            if (out_valid[k]) begin
                if (f_cyc < 0) f_cyc = cyc;
                check("out_data", out_data[k], exp_q[0]);
                check("out_last", out_last[k], (got == n - 1));
                if (r) begin
                    void'(exp_q.pop_front());
                    got++;
                    l_cyc = cyc;
                end
            end
            prev_hold    = out_valid[k] && !r;
            out_ready[k] = r;
            cyc++;
        end
        check("drain_count", got, n);
    endtask

    task automatic done_check(input int k);
        @(negedge clk);
        out_ready[k] = 1'b0;
        check("frame_done_pulse", frame_done[k], 1);
        check("busy_after_frame", busy[k], 0);
        check("fill_after_frame", fill_count[k], 0);
        check("valid_after_frame", out_valid[k], 0);
        @(negedge clk);
        check("frame_done_single", frame_done[k], 0);
    endtask

    initial begin
        rst       = 1'b0;
        clear     = '0;
        wr_en     = '0;
        wr_data   = '0;
        out_ready = '0;

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_busy", busy[k], 0);
            check("rst_valid", out_valid[k], 0);
            check("rst_fill", fill_count[k], 0);
            check("rst_overflow", overflow[k], 0);
            check("rst_data", out_data[k], 0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Forward order
        stim_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        exp_q.delete();
        write_frame(0, 1'b0);
        @(negedge clk);
        wr_en[0] = 1'b0;
        check("fwd_busy", busy[0], 1);
        check("fwd_fill", fill_count[0], 4);
        drain(0, 4, 0, 12, first_cyc, last_cyc);
        check("fwd_first_latency", (first_cyc >= 0 && first_cyc <= 1), 1);
        check("fwd_no_bubbles", last_cyc - first_cyc, 3);
        done_check(0);

        // Reverse order
        exp_q.delete();
        write_frame(1, 1'b1);
        @(negedge clk);
        wr_en[1] = 1'b0;
        check("rev_busy", busy[1], 1);
        drain(1, 4, 0, 12, first_cyc, last_cyc);
        check("rev_first_latency", (first_cyc >= 0 && first_cyc <= 1), 1);
        check("rev_no_bubbles", last_cyc - first_cyc, 3);
        done_check(1);

        // Back-pressure
        stim_q = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1008};
        exp_q.delete();
        write_frame(2, 1'b0);
        @(negedge clk);
        wr_en[2] = 1'b0;
        drain(2, 8, 1, 40, first_cyc, last_cyc);
        done_check(2);

        // Overflow: wr_en held high with 0xDEAD through the whole drain
        exp_q.delete();
        write_frame(2, 1'b0);
        @(negedge clk);
        wr_data[2] = 16'hDEAD;
        check("ovf_busy", busy[2], 1);
        drain(2, 8, 2, 40, first_cyc, last_cyc);
        @(negedge clk);
        wr_en[2]     = 1'b0;
        out_ready[2] = 1'b0;
        check("ovf_done_pulse", frame_done[2], 1);
        check("ovf_sticky", overflow[2], 1);
        check("ovf_fill_zero", fill_count[2], 0);
        @(negedge clk);
        wr_en[2]   = 1'b1;
        wr_data[2] = 16'h0055;
        @(negedge clk);
        wr_data[2] = 16'h0066;
        check("next_frame_fill1", fill_count[2], 1);
        check("ovf_still_set", overflow[2], 1);
        @(negedge clk);
        wr_data[2] = 16'h0067;

        // Clear together with wr_en at fill_count 3
        @(negedge clk);
        check("pre_clear_fill", fill_count[2], 3);
        clear[2]   = 1'b1;
        wr_data[2] = 16'h0077;
        @(negedge clk);
        clear[2] = 1'b0;
        wr_en[2] = 1'b0;
        check("clear_fill", fill_count[2], 0);
        check("clear_overflow", overflow[2], 0);
        check("clear_busy", busy[2], 0);
        check("clear_valid", out_valid[2], 0);

        stim_q = '{16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005, 16'h2006, 16'h2007, 16'h2008};
        exp_q.delete();
        write_frame(2, 1'b0);
        @(negedge clk);
        wr_en[2] = 1'b0;
        drain(2, 8, 0, 20, first_cyc, last_cyc);
        check("post_clear_no_bubbles", last_cyc - first_cyc, 7);
        done_check(2);
        check("post_clear_no_overflow", overflow[2], 0);

        // Asynchronous reset mid-drain
        stim_q = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        exp_q.delete();
        write_frame(0, 1'b0);
        @(negedge clk);
        wr_en[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_valid", out_valid[0], 1);
        check("pre_rst_busy", busy[0], 1);
        check("pre_rst_data", out_data[0], 16'h00A1);
        #1 rst = 1'b0;
        #1;
        check("arst_valid", out_valid[0], 0);
        check("arst_data", out_data[0], 0);
        check("arst_last", out_last[0], 0);
        check("arst_done", frame_done[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_overflow", overflow[0], 0);
        check("arst_fill", fill_count[0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy[0], 0);

        // Full DEPTH-sized frame
        stim_q.delete();
        exp_q.delete();
        for (int i = 0; i < 1024; i++) stim_q.push_back(16'(i));
        foreach (stim_q[i]) begin
            @(negedge clk);
            if (i == 1023) begin
                check("full_fill_1023", fill_count[3], 1023);
                check("full_busy_low", busy[3], 0);
            end
            wr_en[3]   = 1'b1;
            wr_data[3] = stim_q[i];
            exp_q.push_back(stim_q[i]);
        end
        @(negedge clk);
        wr_en[3] = 1'b0;
        check("full_fill_1024", fill_count[3], 1024);
        check("full_busy", busy[3], 1);
        drain(3, 1024, 0, 1100, first_cyc, last_cyc);
        check("full_no_bubbles", last_cyc - first_cyc, 1023);
        done_check(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
